// File: rtl/gnw_pkg.sv
// Shared types and constants for the LCD asset loader and the LCD reader.
package gnw_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WRITE,
    FLUSH,
    DONE
  } state_e;

  localparam int PAL_BYTES_DEF = 768;
  localparam int FB_W_DEF      = 800;
  localparam int FB_H_DEF      = 480;

  // Field positions inside a 16-bit mask/background word {cid,id,col,row}
  localparam int CID_MSB = 15;
  localparam int ID_LSB  = 6;
  localparam int COL_LSB = 2;
  localparam int ROW_LSB = 0;

  function automatic logic [24:0] img_bytes(input int w, input int h);
    return 25'(w * h * 2);
  endfunction

endpackage

// File: rtl/gnw_byte_packer.sv
// Pairs image bytes into 16-bit SDRAM words: holds the even (high) byte and
// forms the word and its byte address when the odd byte or a flush arrives.
module gnw_byte_packer #(
  parameter int SDRAM_BASE = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        even_wr,
  input  logic        odd_wr,
  input  logic        flush_wr,
  input  logic [7:0]  byte_in,
  input  logic [23:0] off_word,
  output logic        pending,
  output logic [15:0] word,
  output logic [24:0] addr
);

  logic [7:0]  hi_q, hi_d;
  logic        pending_q, pending_d;
  logic [24:0] even_addr_q, even_addr_d;
  logic [15:0] word_q, word_d;
  logic [24:0] addr_q, addr_d;
  logic [24:0] word_addr;

  assign word_addr = 25'(SDRAM_BASE) + {off_word, 1'b0};

  always_comb begin
    hi_d        = hi_q;
    pending_d   = pending_q;
    even_addr_d = even_addr_q;
    word_d      = word_q;
    addr_d      = addr_q;
    if (clear) begin
      hi_d      = 8'h00;
      pending_d = 1'b0;
    end else if (even_wr) begin
      // A second even byte simply replaces the first; nothing is written for it.
      hi_d        = byte_in;
      pending_d   = 1'b1;
      even_addr_d = word_addr;
    end else if (odd_wr) begin
      word_d    = {pending_q ? hi_q : 8'h00, byte_in};
      addr_d    = word_addr;
      pending_d = 1'b0;
    end else if (flush_wr) begin
      word_d    = {hi_q, 8'h00};
      addr_d    = even_addr_q;
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q        <= 8'h00;
      pending_q   <= 1'b0;
      even_addr_q <= '0;
      word_q      <= '0;
      addr_q      <= '0;
    end else begin
      hi_q        <= hi_d;
      pending_q   <= pending_d;
      even_addr_q <= even_addr_d;
      word_q      <= word_d;
      addr_q      <= addr_d;
    end
  end

  assign pending = pending_q;
  assign word    = word_q;
  assign addr    = addr_q;

endmodule

// File: rtl/gnw_asset_loader.sv
// Splits the HPS ioctl download into palette writes and packed SDRAM image words.
// Optional GNW_LOADER_CSUM_EN adds a 16-bit running sum of accepted SDRAM words.
module gnw_asset_loader
  import gnw_pkg::*;
#(
  parameter int PAL_BYTES  = PAL_BYTES_DEF,
  parameter int FB_W       = FB_W_DEF,
  parameter int FB_H       = FB_H_DEF,
  parameter int SDRAM_BASE = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic        pal_load,
  output logic [9:0]  pal_addr,
  output logic [7:0]  pal_din,
  output logic [24:0] sdram_addr,
  output logic [15:0] sdram_din,
  output logic        sdram_we,
  input  logic        sdram_rdy,
  output logic        load_done,
`ifdef GNW_LOADER_CSUM_EN
  output logic [15:0] csum,
`endif
  output logic        overflow
);

  localparam logic [24:0] PAL_LIM = 25'(PAL_BYTES);
  localparam logic [24:0] IMG_LIM = img_bytes(FB_W, FB_H);

  state_e      state_q, state_d;
  logic        dl_q;
  logic        pal_load_q, pal_load_d;
  logic [9:0]  pal_addr_q, pal_addr_d;
  logic [7:0]  pal_din_q, pal_din_d;
  logic        we_q, we_d;
  logic        done_q, done_d;
  logic        ovf_q, ovf_d;
  logic        is_flush_q, is_flush_d;
`ifdef GNW_LOADER_CSUM_EN
  logic [15:0] csum_q, csum_d;
`endif

  logic        dl_rise;
  logic [24:0] off;
  logic        pk_clear, pk_even, pk_odd, pk_flush, pk_pending;

  assign dl_rise = ioctl_download & ~dl_q;
  assign off     = ioctl_addr - PAL_LIM;

  always_comb begin
    state_d    = state_q;
    pal_load_d = 1'b0;
    pal_addr_d = pal_addr_q;
    pal_din_d  = pal_din_q;
    we_d       = we_q;
    done_d     = done_q;
    ovf_d      = ovf_q;
    is_flush_d = is_flush_q;
    pk_clear   = 1'b0;
    pk_even    = 1'b0;
    pk_odd     = 1'b0;
    pk_flush   = 1'b0;
`ifdef GNW_LOADER_CSUM_EN
    csum_d     = csum_q;
`endif
    case (state_q)
      IDLE: begin
        if (dl_rise) begin
          done_d   = 1'b0;
          ovf_d    = 1'b0;
          pk_clear = 1'b1;
`ifdef GNW_LOADER_CSUM_EN
          csum_d   = 16'h0000;
`endif
          state_d  = LOAD;
        end
      end
      LOAD: begin
        if (!ioctl_download) begin
          state_d = FLUSH;
        end else if (ioctl_wr) begin
          // Palette range is decided on the raw address, before any subtraction.
          if (ioctl_addr < PAL_LIM) begin
            pal_load_d = 1'b1;
            pal_addr_d = ioctl_addr[9:0];
            pal_din_d  = ioctl_dout;
          end else if (off >= IMG_LIM) begin
            ovf_d = 1'b1;
          end else if (!off[0]) begin
            pk_even = 1'b1;
          end else begin
            pk_odd  = 1'b1;
            we_d    = 1'b1;
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        if (sdram_rdy) begin
          we_d = 1'b0;
`ifdef GNW_LOADER_CSUM_EN
          csum_d = csum_q + sdram_din;
`endif
          if (is_flush_q) begin
            is_flush_d = 1'b0;
            state_d    = DONE;
          end else if (!ioctl_download) begin
            state_d = FLUSH;
          end else begin
            state_d = LOAD;
          end
        end
      end
      FLUSH: begin
        if (pk_pending) begin
          pk_flush   = 1'b1;
          we_d       = 1'b1;
          is_flush_d = 1'b1;
          state_d    = WRITE;
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      dl_q       <= 1'b0;
      pal_load_q <= 1'b0;
      pal_addr_q <= '0;
      pal_din_q  <= '0;
      we_q       <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      is_flush_q <= 1'b0;
`ifdef GNW_LOADER_CSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      dl_q       <= ioctl_download;
      pal_load_q <= pal_load_d;
      pal_addr_q <= pal_addr_d;
      pal_din_q  <= pal_din_d;
      we_q       <= we_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      is_flush_q <= is_flush_d;
`ifdef GNW_LOADER_CSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  gnw_byte_packer #(
    .SDRAM_BASE(SDRAM_BASE)
  ) u_packer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (pk_clear),
    .even_wr  (pk_even),
    .odd_wr   (pk_odd),
    .flush_wr (pk_flush),
    .byte_in  (ioctl_dout),
    .off_word (off[24:1]),
    .pending  (pk_pending),
    .word     (sdram_din),
    .addr     (sdram_addr)
  );

  // hps_io is stalled for exactly as long as a write is outstanding.
  assign ioctl_wait = we_q;
  assign sdram_we   = we_q;
  assign pal_load   = pal_load_q;
  assign pal_addr   = pal_addr_q;
  assign pal_din    = pal_din_q;
  assign load_done  = done_q;
  assign overflow   = ovf_q;
`ifdef GNW_LOADER_CSUM_EN
  assign csum       = csum_q;
`endif

endmodule

// File: tb/tb_gnw_asset_loader.sv
// Directed self-checking bench for gnw_asset_loader (default 768/800x480 build).
module tb_gnw_asset_loader;
  import gnw_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ioctl_download = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic        ioctl_wait;
  logic        pal_load;
  logic [9:0]  pal_addr;
  logic [7:0]  pal_din;
  logic [24:0] sdram_addr;
  logic [15:0] sdram_din;
  logic        sdram_we;
  logic        sdram_rdy = 1'b0;
  logic        load_done;
  logic        overflow;
`ifdef GNW_LOADER_CSUM_EN
  logic [15:0] csum;
`endif

  int errors = 0;
  int checks = 0;

  gnw_asset_loader dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait),
    .pal_load       (pal_load),
    .pal_addr       (pal_addr),
    .pal_din        (pal_din),
    .sdram_addr     (sdram_addr),
    .sdram_din      (sdram_din),
    .sdram_we       (sdram_we),
    .sdram_rdy      (sdram_rdy),
    .load_done      (load_done),
`ifdef GNW_LOADER_CSUM_EN
    .csum           (csum),
`endif
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  // One-cycle byte strobe; returns on the negedge after the capturing posedge.
  task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
    @(negedge clk);
    ioctl_wr   = 1'b1;
    ioctl_addr = a;
    ioctl_dout = d;
    @(negedge clk);
    ioctl_wr   = 1'b0;
  endtask

  // Plays the SDRAM controller: asserts rdy on the lat-th cycle of sdram_we.
  task automatic sdram_accept(input int lat, output int cycles, output int wait_bad,
                              output logic [24:0] a, output logic [15:0] d,
                              output bit timed_out);
    int k;
    cycles = 0; wait_bad = 0; a = '0; d = '0; timed_out = 1'b0; k = 0;
    while (!sdram_we && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!sdram_we) begin
      timed_out = 1'b1;
      return;
    end
    while (sdram_we && cycles < 50) begin
      cycles++;
      a = sdram_addr;
      d = sdram_din;
      if (ioctl_wait !== 1'b1) wait_bad++;
      if (cycles == lat) sdram_rdy = 1'b1;
      @(negedge clk);
      sdram_rdy = 1'b0;
    end
    if (sdram_we) timed_out = 1'b1;
  endtask

  task automatic wait_done();
    for (int k = 0; k < 12 && !load_done; k++) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({sdram_we, ioctl_wait, pal_load, load_done, overflow} !== 5'b0 ||
        sdram_addr !== 25'd0 || sdram_din !== 16'd0 || pal_addr !== 10'd0) begin
      errors++;
      $display("FAIL reset_outputs: got we=%b wait=%b pal=%b done=%b ovf=%b addr=%h din=%h, expected all 0",
               sdram_we, ioctl_wait, pal_load, load_done, overflow, sdram_addr, sdram_din);
    end
    rst_n = 1'b1;
    @(negedge clk);
    ioctl_download = 1'b1;
    @(negedge clk);
    send_byte(25'd768, 8'hA5);
    send_byte(25'd769, 8'h3C);
    checks++;
    if (sdram_we !== 1'b1) begin
      errors++;
      $display("FAIL reset_pre_write: sdram_we=%b expected 1", sdram_we);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({sdram_we, ioctl_wait, pal_load} !== 3'b000 || dut.state_q !== IDLE) begin
      errors++;
      $display("FAIL reset_mid_write: we=%b wait=%b pal=%b state=%0d expected 0,0,0,IDLE",
               sdram_we, ioctl_wait, pal_load, dut.state_q);
    end
    ioctl_download = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    $display("test_reset done");
  endtask

  task automatic test_palette();
    int bad;
    bad = 0;
    ioctl_download = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 768; i++) begin
      logic [24:0] a;
      a = 25'(i);
      send_byte(a, a[7:0]);
      checks++;
      if (pal_load !== 1'b1 || pal_addr !== a[9:0] || pal_din !== a[7:0] || sdram_we !== 1'b0) begin
        errors++;
        if (bad < 5)
          $display("FAIL palette_byte %0d: pal_load=%b addr=%0d din=%h we=%b, expected 1,%0d,%h,0",
                   i, pal_load, pal_addr, pal_din, sdram_we, i, a[7:0]);
        bad++;
      end
    end
    @(negedge clk);
    checks++;
    if (pal_load !== 1'b0) begin
      errors++;
      $display("FAIL palette_pulse_width: pal_load=%b expected 0", pal_load);
    end
    $display("test_palette: 768 bytes sent");
  endtask

  task automatic test_image_word();
    int cyc, wbad;
    logic [24:0] a;
    logic [15:0] d;
    bit to;
    send_byte(25'd768, 8'hA5);
    send_byte(25'd769, 8'h3C);
    sdram_accept(3, cyc, wbad, a, d, to);
    checks++;
    if (to || cyc != 3 || wbad != 0 || a !== 25'd0 || d !== 16'hA53C) begin
      errors++;
      $display("FAIL image_word: to=%0d we_cycles=%0d wait_bad=%0d addr=%h din=%h, expected 0,3,0,0,a53c",
               to, cyc, wbad, a, d);
    end
    checks++;
    if (ioctl_wait !== 1'b0) begin
      errors++;
      $display("FAIL image_wait_release: ioctl_wait=%b expected 0", ioctl_wait);
    end
    $display("test_image_word: addr=%h din=%h we_cycles=%0d", a, d, cyc);
  endtask

  task automatic test_flush();
    int cyc, wbad;
    logic [24:0] a;
    logic [15:0] d;
    bit to;
    send_byte(25'd770, 8'h7F);
    checks++;
    if (sdram_we !== 1'b0) begin
      errors++;
      $display("FAIL flush_even_no_write: sdram_we=%b expected 0", sdram_we);
    end
    ioctl_download = 1'b0;
    sdram_accept(1, cyc, wbad, a, d, to);
    checks++;
    if (to || cyc != 1 || a !== 25'd2 || d !== 16'h7F00) begin
      errors++;
      $display("FAIL flush_write: to=%0d we_cycles=%0d addr=%h din=%h, expected 0,1,2,7f00",
               to, cyc, a, d);
    end
    wait_done();
    checks++;
    if (load_done !== 1'b1) begin
      errors++;
      $display("FAIL flush_load_done: load_done=%b expected 1", load_done);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (load_done !== 1'b1) begin
      errors++;
      $display("FAIL load_done_sticky: load_done=%b expected 1", load_done);
    end
    $display("test_flush: addr=%h din=%h", a, d);
  endtask

  task automatic test_overflow();
    int cyc, wbad;
    logic [24:0] a;
    logic [15:0] d;
    bit to;
    ioctl_download = 1'b1;
    @(negedge clk);
    checks++;
    if (load_done !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL start_clear: load_done=%b overflow=%b expected 0,0", load_done, overflow);
    end
    // Last odd byte of the image, no preceding even byte.
    send_byte(25'd768767, 8'h5A);
    sdram_accept(1, cyc, wbad, a, d, to);
    checks++;
    if (to || a !== 25'd767998 || d !== 16'h005A) begin
      errors++;
      $display("FAIL last_word: to=%0d addr=%0d din=%h, expected 0,767998,005a", to, a, d);
    end
    send_byte(25'd772, 8'h11);
    send_byte(25'd774, 8'h22);
    checks++;
    if (sdram_we !== 1'b0) begin
      errors++;
      $display("FAIL even_overwrite_no_write: sdram_we=%b expected 0", sdram_we);
    end
    send_byte(25'd775, 8'h33);
    sdram_accept(1, cyc, wbad, a, d, to);
    checks++;
    if (to || a !== 25'd6 || d !== 16'h2233) begin
      errors++;
      $display("FAIL even_overwrite_word: to=%0d addr=%h din=%h, expected 0,6,2233", to, a, d);
    end
    send_byte(25'd768768, 8'h77);
    checks++;
    if (overflow !== 1'b1 || sdram_we !== 1'b0) begin
      errors++;
      $display("FAIL overflow_byte: overflow=%b we=%b expected 1,0", overflow, sdram_we);
    end
    // Odd byte, then download ends and a stray byte arrives while stalled.
    send_byte(25'd777, 8'h44);
    ioctl_download = 1'b0;
    checks++;
    if (ioctl_wait !== 1'b1) begin
      errors++;
      $display("FAIL wait_before_stray: ioctl_wait=%b expected 1", ioctl_wait);
    end
    ioctl_wr = 1'b1; ioctl_addr = 25'd778; ioctl_dout = 8'h99;
    @(negedge clk);
    ioctl_wr = 1'b0;
    sdram_accept(1, cyc, wbad, a, d, to);
    checks++;
    if (to || a !== 25'd8 || d !== 16'h0044) begin
      errors++;
      $display("FAIL fall_during_write: to=%0d addr=%h din=%h, expected 0,8,0044", to, a, d);
    end
    begin
      int extra_we;
      extra_we = 0;
      for (int k = 0; k < 12 && !load_done; k++) begin
        if (sdram_we) extra_we++;
        @(negedge clk);
      end
      checks++;
      if (extra_we != 0 || load_done !== 1'b1) begin
        errors++;
        $display("FAIL stray_byte_dropped: extra_we_cycles=%0d load_done=%b, expected 0,1",
                 extra_we, load_done);
      end
    end
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_sticky: overflow=%b expected 1", overflow);
    end
    ioctl_download = 1'b1;
    @(negedge clk);
    checks++;
    if (overflow !== 1'b0 || load_done !== 1'b0) begin
      errors++;
      $display("FAIL overflow_clear: overflow=%b load_done=%b expected 0,0", overflow, load_done);
    end
    ioctl_download = 1'b0;
    wait_done();
    checks++;
    if (load_done !== 1'b1 || sdram_we !== 1'b0) begin
      errors++;
      $display("FAIL empty_download_done: load_done=%b we=%b expected 1,0", load_done, sdram_we);
    end
    $display("test_overflow: boundary, overwrite, overflow and stray byte cases run");
  endtask

`ifdef GNW_LOADER_CSUM_EN
  task automatic test_csum();
    int cyc, wbad;
    logic [24:0] a;
    logic [15:0] d;
    bit to;
    ioctl_download = 1'b1;
    @(negedge clk);
    send_byte(25'd768, 8'hFF);
    send_byte(25'd769, 8'hFF);
    sdram_accept(2, cyc, wbad, a, d, to);
    send_byte(25'd770, 8'h00);
    send_byte(25'd771, 8'h02);
    sdram_accept(1, cyc, wbad, a, d, to);
    ioctl_download = 1'b0;
    wait_done();
    checks++;
    if (load_done !== 1'b1 || csum !== 16'h0001) begin
      errors++;
      $display("FAIL csum: load_done=%b csum=%h expected 1,0001", load_done, csum);
    end
    $display("test_csum: csum=%h", csum);
  endtask
`endif

  initial begin
    test_reset();
    test_palette();
    test_image_word();
    test_flush();
    test_overflow();
`ifdef GNW_LOADER_CSUM_EN
    test_csum();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
